// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported, fixed-latency memory between the
// instruction-fetch port (IF) and the memory-stage data port (D). Each access
// is arbitrated, issued, waited out for LATENCY cycles and then returned. D wins
// ties, but a starvation counter forces an IF grant after STARVE_MAX
// consecutive D grants taken while IF was waiting.
module mem_port_arbiter #(
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        stall,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        BUSY_IF,
        BUSY_D,
        RESP_IF,
        RESP_D
    } state_t;

    localparam logic [3:0] WAIT_INIT  = 4'(LATENCY - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("mem_port_arbiter: LATENCY must be within 1..15");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
        $error("mem_port_arbiter: STARVE_MAX must be within 1..15");
    end

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [3:0]  starve_q, starve_d;
    logic        if_gnt_q, if_gnt_d;
    logic        d_gnt_q, d_gnt_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic        d_rvalid_q, d_rvalid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        d_wins;

    // D takes the slot unless IF is waiting and has already been passed over STARVE_MAX times
    always_comb begin
        d_wins = d_req && !(if_req && (starve_q == STARVE_LIM));
    end

    // Next-state and registered-output logic: arbitrate in IDLE, count out the latency, capture the response
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        starve_d    = starve_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        mem_en_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (d_wins) begin
                    mem_en_d    = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    d_gnt_d     = 1'b1;
                    wait_d      = WAIT_INIT;
                    state_d     = BUSY_D;
                    if (!if_req) begin
                        starve_d = 4'd0;
                    end else if (starve_q != STARVE_LIM) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (if_req) begin
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = 32'd0;
                    if_gnt_d    = 1'b1;
                    wait_d      = WAIT_INIT;
                    state_d     = BUSY_IF;
                    starve_d    = 4'd0;
                end
            end
            BUSY_IF: begin
                if (wait_q == 4'd0) begin
                    state_d = RESP_IF;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            BUSY_D: begin
                if (wait_q == 4'd0) begin
                    state_d = RESP_D;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            RESP_IF: begin
                if_rvalid_d = 1'b1;
                if_rdata_d  = mem_rdata;
                state_d     = IDLE;
            end
            RESP_D: begin
                d_rvalid_d = 1'b1;
                if (!mem_we_q) begin
                    d_rdata_d = mem_rdata;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_q      <= 4'd0;
            starve_q    <= 4'd0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            starve_q    <= starve_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Stalls drop in the rvalid cycle so the requesting stage can advance
    always_comb begin
        if_stall = if_req & ~if_rvalid_q;
        stall    = d_req & ~d_rvalid_q;
    end

    assign if_gnt    = if_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiter instances (LATENCY=2/STARVE_MAX=4 and
// LATENCY=1/STARVE_MAX=2) driven by random pipeline-style requesters and a
// bench-owned memory, checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int NI   = 2;
    localparam int LAT0 = 2;
    localparam int LAT1 = 1;
    localparam int SM0  = 4;
    localparam int SM1  = 2;

    logic        clk;
    logic        rst;
    logic        if_req    [NI];
    logic [31:0] if_addr   [NI];
    logic        d_req     [NI];
    logic        d_we      [NI];
    logic [31:0] d_addr    [NI];
    logic [31:0] d_wdata   [NI];
    logic [31:0] mem_rdata [NI];
    logic        if_gnt    [NI];
    logic        if_rvalid [NI];
    logic [31:0] if_rdata  [NI];
    logic        if_stall  [NI];
    logic        d_gnt     [NI];
    logic        d_rvalid  [NI];
    logic [31:0] d_rdata   [NI];
    logic        stall     [NI];
    logic        mem_en    [NI];
    logic        mem_we    [NI];
    logic [31:0] mem_addr  [NI];
    logic [31:0] mem_wdata [NI];

    mem_port_arbiter #(.LATENCY(LAT0), .STARVE_MAX(SM0)) dut0 (
        .clk(clk), .rst(rst),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
        .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]), .if_stall(if_stall[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]), .stall(stall[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    mem_port_arbiter #(.LATENCY(LAT1), .STARVE_MAX(SM1)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
        .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]), .if_stall(if_stall[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]), .stall(stall[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Absolute time limit so a wedged run still ends with a report
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, want completion");
        $fatal(1, "[TB] watchdog");
    end

    int          cyc;
    int          vec_count;
    int          err_count;

    // Transaction-level model: one outstanding access per instance
    int          samp      [NI];
    int          starve    [NI];
    int          iss_c     [NI];
    bit          act       [NI];
    bit          iss_d     [NI];
    bit          iss_we    [NI];
    logic [31:0] iss_addr  [NI];
    logic [31:0] iss_wdata [NI];
    logic [31:0] iss_rd    [NI];
    logic [31:0] e_mem_addr  [NI];
    logic [31:0] e_mem_wdata [NI];
    logic [31:0] e_if_rdata  [NI];
    logic [31:0] e_d_rdata   [NI];
    logic [31:0] mem_arr [NI][128];

    bit          fix_if;
    bit          fix_d;
    logic        fix_d_we;
    logic [31:0] fix_d_addr;
    logic [31:0] fix_d_wdata;

    function automatic int lat(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int smax(input int i);
        return (i == 0) ? SM0 : SM1;
    endfunction

    function automatic logic [7:0] obs_ctl(input int i);
        return {if_gnt[i], d_gnt[i], if_rvalid[i], d_rvalid[i],
                if_stall[i], stall[i], mem_en[i], mem_we[i] & mem_en[i]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_count++;
        if (obs !== exp) begin
            err_count++;
            $display("[TB] FAIL %s @cycle %0d: got %h, want %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string where);
        for (int i = 0; i < NI; i++) begin
            checkOutput($sformatf("%s.ctl%0d", where, i), {24'd0, obs_ctl(i)}, 32'd0);
            checkOutput($sformatf("%s.mem_we%0d", where, i), {31'd0, mem_we[i]}, 32'd0);
            checkOutput($sformatf("%s.mem_addr%0d", where, i), mem_addr[i], 32'd0);
            checkOutput($sformatf("%s.mem_wdata%0d", where, i), mem_wdata[i], 32'd0);
            checkOutput($sformatf("%s.if_rdata%0d", where, i), if_rdata[i], 32'd0);
            checkOutput($sformatf("%s.d_rdata%0d", where, i), d_rdata[i], 32'd0);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            act[i]         = 1'b0;
            starve[i]      = 0;
            samp[i]        = cyc + 1;
            e_mem_addr[i]  = 32'd0;
            e_mem_wdata[i] = 32'd0;
            e_if_rdata[i]  = 32'd0;
            e_d_rdata[i]   = 32'd0;
        end
    endtask

    task automatic new_if(input int i);
        logic [31:0] a;
        a = $urandom();
        if_req[i]  = 1'b1;
        if_addr[i] = fix_if ? 32'h0000_0100 : a;
    endtask

    task automatic new_d(input int i, input int pwe);
        logic [31:0] a;
        logic [31:0] w;
        a = $urandom();
        w = $urandom();
        d_req[i]   = 1'b1;
        d_we[i]    = fix_d ? fix_d_we : ($urandom_range(99) < pwe);
        d_addr[i]  = fix_d ? fix_d_addr : a;
        d_wdata[i] = fix_d ? fix_d_wdata : w;
    endtask

    // One clock cycle: drive requesters and memory, check every output, then arbitrate in the model
    task automatic applyStimulus(input int pif, input int pd, input int pwe);
        bit          if_done [NI];
        bit          d_done  [NI];
        bit          if_busy;
        bit          d_busy;
        bit          e_gnt;
        bit          win_d;
        logic [7:0]  e_ctl;
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < NI; i++) begin
            if_done[i] = act[i] && !iss_d[i] && (cyc == iss_c[i] + lat(i) + 1);
            d_done[i]  = act[i] &&  iss_d[i] && (cyc == iss_c[i] + lat(i) + 1);
            if_busy    = act[i] && !iss_d[i] && (cyc >= iss_c[i]) && !if_done[i];
            d_busy     = act[i] &&  iss_d[i] && (cyc >= iss_c[i]) && !d_done[i];

            if (if_done[i] || (!if_busy && !if_req[i])) begin
                if ($urandom_range(99) < pif) new_if(i);
                else if_req[i] = 1'b0;
            end else if (if_busy && if_req[i] && pif < 100 && $urandom_range(99) < 10) begin
                if_req[i] = 1'b0;
            end

            if (d_done[i] || (!d_busy && !d_req[i])) begin
                if ($urandom_range(99) < pd) new_d(i, pwe);
                else d_req[i] = 1'b0;
            end else if (d_busy && d_req[i] && pd < 100 && $urandom_range(99) < 10) begin
                d_req[i] = 1'b0;
            end

            mem_rdata[i] = $urandom();
            if (act[i] && !iss_we[i] && (cyc == iss_c[i] + lat(i))) begin
                mem_rdata[i] = iss_rd[i];
            end
        end
        #2;
        for (int i = 0; i < NI; i++) begin
            e_gnt = act[i] && (cyc == iss_c[i]);
            if (e_gnt) begin
                e_mem_addr[i]  = iss_addr[i];
                e_mem_wdata[i] = iss_wdata[i];
            end
            if (if_done[i]) e_if_rdata[i] = iss_rd[i];
            if (d_done[i] && !iss_we[i]) e_d_rdata[i] = iss_rd[i];
            e_ctl = {e_gnt && !iss_d[i], e_gnt && iss_d[i], if_done[i], d_done[i],
                     if_req[i] && !if_done[i], d_req[i] && !d_done[i],
                     e_gnt, e_gnt && iss_we[i]};

            checkOutput($sformatf("ctl%0d", i), {24'd0, obs_ctl(i)}, {24'd0, e_ctl});
            checkOutput($sformatf("mem_addr%0d", i), mem_addr[i], e_mem_addr[i]);
            checkOutput($sformatf("mem_wdata%0d", i), mem_wdata[i], e_mem_wdata[i]);
            checkOutput($sformatf("if_rdata%0d", i), if_rdata[i], e_if_rdata[i]);
            checkOutput($sformatf("d_rdata%0d", i), d_rdata[i], e_d_rdata[i]);

            if (if_done[i] || d_done[i]) act[i] = 1'b0;

            if (cyc == samp[i]) begin
                if (if_req[i] || d_req[i]) begin
                    win_d    = d_req[i] && !(if_req[i] && starve[i] == smax(i));
                    act[i]   = 1'b1;
                    iss_c[i] = cyc + 1;
                    iss_d[i] = win_d;
                    if (win_d) begin
                        iss_we[i]    = d_we[i];
                        iss_addr[i]  = d_addr[i];
                        iss_wdata[i] = d_wdata[i];
                        if (if_req[i]) starve[i] = (starve[i] < smax(i)) ? starve[i] + 1 : smax(i);
                        else starve[i] = 0;
                    end else begin
                        iss_we[i]    = 1'b0;
                        iss_addr[i]  = if_addr[i];
                        iss_wdata[i] = 32'd0;
                        starve[i]    = 0;
                    end
                    iss_rd[i] = mem_arr[i][iss_addr[i][8:2]];
                    if (iss_we[i]) mem_arr[i][iss_addr[i][8:2]] = iss_wdata[i];
                    samp[i] = cyc + lat(i) + 2;
                end else begin
                    samp[i] = cyc + 1;
                end
            end
        end
    endtask

    // Pulse reset in the BUSY_D cycle right after a D grant on the LATENCY=2 instance
    task automatic resetMidBusy();
        bit found;
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            applyStimulus(0, 100, 0);
            found = act[0] && iss_d[0] && (cyc == iss_c[0]);
        end
        checkOutput("seek_d_gnt", {31'd0, found}, 32'd1);
        applyStimulus(0, 100, 0);
        #1;
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            if_req[i] = 1'b0;
            d_req[i]  = 1'b0;
        end
        #1;
        checkAllZero("async_rst");
        @(posedge clk);
        cyc++;
        #1;
        checkAllZero("held_rst");
        #3;
        rst = 1'b0;
        model_reset();
    endtask

    // Test sequence: directed IF read and D read/write, contention, held D, mid-access reset, random traffic
    initial begin
        rst       = 1'b1;
        cyc       = 0;
        vec_count = 0;
        err_count = 0;
        fix_if    = 1'b0;
        fix_d     = 1'b0;
        fix_d_we  = 1'b0;
        fix_d_addr  = 32'd0;
        fix_d_wdata = 32'd0;
        for (int i = 0; i < NI; i++) begin
            if_req[i]    = 1'b0;
            if_addr[i]   = 32'd0;
            d_req[i]     = 1'b0;
            d_we[i]      = 1'b0;
            d_addr[i]    = 32'd0;
            d_wdata[i]   = 32'd0;
            mem_rdata[i] = 32'd0;
            for (int j = 0; j < 128; j++) mem_arr[i][j] = $urandom();
            mem_arr[i][64] = 32'hDEAD_BEEF;
        end

        @(posedge clk);
        @(posedge clk);
        #1;
        checkAllZero("reset");
        #3;
        rst = 1'b0;
        model_reset();

        fix_if = 1'b1;
        repeat (10) applyStimulus(100, 0, 0);
        fix_if = 1'b0;
        repeat (2) applyStimulus(0, 0, 0);

        fix_d       = 1'b1;
        fix_d_we    = 1'b0;
        fix_d_addr  = 32'h0000_0100;
        repeat (6) applyStimulus(0, 100, 0);
        fix_d_we    = 1'b1;
        fix_d_addr  = 32'h0000_0040;
        fix_d_wdata = 32'h1234_5678;
        repeat (10) applyStimulus(0, 100, 0);
        fix_d = 1'b0;
        repeat (4) applyStimulus(0, 0, 0);

        repeat (80) applyStimulus(100, 100, 50);
        repeat (6) applyStimulus(0, 0, 0);
        repeat (40) applyStimulus(0, 100, 30);

        resetMidBusy();

        repeat (1500) applyStimulus(40, 40, 50);
        repeat (500) applyStimulus(80, 80, 50);
        resetMidBusy();
        repeat (300) applyStimulus(60, 60, 40);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
